vcm_i2c_slave: RTL and testbench
================================

VCM_I2C_SLAVE -- requirements
Module: vcm_i2c_slave

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h0C, the 7-bit I2C address the block responds to.
REQ-002 The block SHALL have parameter FILT_LEN, default 3, the number of consecutive equal synchronized samples needed to accept a new SCL/SDA level.
REQ-003 The block SHALL have port CLK_50, input, 1 bit, the system clock; the design SHALL use one clock only.
REQ-004 The block SHALL have port RESET_N, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port SCL, input, 1 bit, the I2C clock from the bus master.
REQ-006 The block SHALL have port SDA, inout, 1 bit, open-drain I2C data; the block SHALL only drive 0 or release it to Z.
REQ-007 The block SHALL have port VCM_DATA, output, 16 bits, the last complete focus word written.
REQ-008 The block SHALL have port VCM_UPDATE, output, 1 bit, a one-cycle pulse when VCM_DATA is loaded.
REQ-009 The block SHALL have port BUSY, output, 1 bit, high from an addressed START until the next STOP.
REQ-010 The block SHALL have port STATUS, output, 4 bits, driven as {addr_match, rw_bit, byte_cnt[1:0]} for debug.

Function
REQ-011 SCL and SDA SHALL each pass through a 2-flop synchronizer, then a filter that changes its output only after FILT_LEN identical samples.
REQ-012 START SHALL be a filtered SDA 1->0 while filtered SCL=1; STOP SHALL be a filtered SDA 0->1 while filtered SCL=1; both SHALL be detected in any state.
REQ-013 Data SHALL be sampled on the filtered SCL rising edge, MSB first; the SDA drive SHALL change only on the cycle after a filtered SCL falling edge.
REQ-014 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-015 Transitions: START->ADDR from any state; after 8 bits in ADDR, a match with SLAVE_ADDR goes to ADDR_ACK (SDA driven low for the 9th clock) and a mismatch goes to WAIT_STOP with SDA released.
REQ-016 After ADDR_ACK the FSM SHALL go to WR_BYTE when R/W=0, or RD_BYTE when R/W=1.
REQ-017 Every received write byte SHALL be ACKed in WR_ACK; the first byte after the address SHALL be held as the pending MSB, and the second SHALL be the LSB.
REQ-018 On the SCL rising edge that samples bit 0 of the LSB byte, VCM_DATA SHALL take {pending MSB, LSB} and VCM_UPDATE SHALL pulse high one cycle later for exactly one cycle.
REQ-019 Bytes after the 2nd SHALL form further MSB/LSB pairs; byte_cnt SHALL wrap 0..1 per pair, and each completed pair SHALL update VCM_DATA.
REQ-020 A STOP or repeated START with an odd byte pending SHALL discard that byte and leave VCM_DATA unchanged.
REQ-021 Reads SHALL return VCM_DATA[15:8] then VCM_DATA[7:0], alternating; the shift register SHALL be loaded at the ADDR_ACK/RD_ACK exit.
REQ-022 In RD_ACK the block SHALL release SDA and sample the master ACK; ACK=0 SHALL continue to RD_BYTE and ACK=1 (NACK) SHALL go to WAIT_STOP.
REQ-023 WAIT_STOP SHALL keep SDA released until STOP->IDLE or START->ADDR.
REQ-024 BUSY SHALL go high at ADDR_ACK entry and go low on STOP; a repeated START SHALL keep BUSY high only if the new address matches.

Reset
REQ-025 When RESET_N=0, the block SHALL asynchronously clear the FSM to IDLE, release SDA to Z, and set VCM_DATA=16'h0000, VCM_UPDATE=0, BUSY=0, STATUS=0, filters=1 and the pending byte to 0.
REQ-026 A reset mid-transaction SHALL abort the transaction with no VCM_UPDATE, and the block SHALL respond normally from the next START.

Configuration
REQ-027 With macro VCM_SLAVE_READ_EN defined, read support (REQ-021/022) SHALL be compiled in.
REQ-028 With VCM_SLAVE_READ_EN undefined, the RD states SHALL be absent, and a matching address with R/W=1 SHALL be NACKed and go to WAIT_STOP.

Verification
REQ-029 Write test: S, 0x18, 0x12, 0x34, P -> three ACKs, VCM_DATA=16'h1234, exactly one VCM_UPDATE pulse, BUSY low after P.
REQ-030 Wrong address: S, 0x1A, 0xFF, P -> SDA never driven low, VCM_DATA unchanged, BUSY stays 0.
REQ-031 Odd-byte write: S, 0x18, 0x12, 0x34, 0x56, P -> VCM_DATA=16'h1234, one update pulse, 0x56 discarded.
REQ-032 Read with READ_EN: after writing 0xABCD, S, 0x19, read 2 bytes with ACK then NACK, P -> 0xAB then 0xCD; without READ_EN the address byte is NACKed.
REQ-033 Glitch test: a 2-cycle SCL low pulse mid-byte is ignored and the byte is still received correctly; a repeated START after one data byte restarts at ADDR and leaves VCM_DATA unchanged.
REQ-034 Reset test: RESET_N asserted during the LSB byte -> SDA=Z, VCM_DATA=0 immediately, and a following full write succeeds.

Source files
------------

// File: rtl/vcm_i2c_slave.sv
// ---------------------------------------------------------------------------
// vcm_i2c_slave
//   Write-mostly I2C slave that receives 16-bit voice-coil-motor focus words.
//   Bytes after the address pair up as {MSB, LSB}. Each completed pair loads
//   VCM_DATA and produces a one-cycle VCM_UPDATE strobe. An odd trailing byte
//   is dropped at STOP or at a repeated START.
//
//   Build option: define VCM_SLAVE_READ_EN to compile in read support.
//   Reads return VCM_DATA[15:8] and VCM_DATA[7:0], alternating. Without the
//   macro, a read address is NACKed and the block waits for STOP.
//
// Parameters
//   SLAVE_ADDR  7-bit bus address (default 7'h0C)
//   FILT_LEN    consecutive equal samples needed to accept a new SCL/SDA level
//
// Ports
//   CLK_50      system clock (only clock in the design)
//   RESET_N     asynchronous active-low reset
//   SCL         bus clock from the master
//   SDA         open-drain bus data; this block only pulls it to 0 or releases it
//   VCM_DATA    last complete focus word written
//   VCM_UPDATE  one-cycle pulse, one cycle after VCM_DATA is loaded
//   BUSY        high from an acknowledged address until STOP
//   STATUS      {addr_match, rw_bit, byte_cnt[1:0]} for debug
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module vcm_i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h0C,
   parameter int         FILT_LEN   = 3
) (
   input  logic        CLK_50,
   input  logic        RESET_N,
   input  logic        SCL,
   inout  wire         SDA,
   output logic [15:0] VCM_DATA,
   output logic        VCM_UPDATE,
   output logic        BUSY,
   output logic [3:0]  STATUS
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_BYTE,
      WR_ACK,
      WAIT_STOP
`ifdef VCM_SLAVE_READ_EN
      , RD_BYTE,
      RD_ACK
`endif
   } state_t;

   localparam int CNT_W = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;

   state_t           state;
   state_t           state_nxt;

   // Bit 1 carries SCL, bit 0 carries SDA.
   logic [1:0]       meta;
   logic [1:0]       sync;
   logic [1:0]       filt;
   logic [1:0]       filt_q;
   logic [CNT_W-1:0] fcnt [2];

   logic             scl_rise;
   logic             scl_fall;
   logic             start_det;
   logic             stop_det;

   logic [6:0]       rx_sh;
   logic [7:0]       rx_byte;
   logic [7:0]       pend;
   logic [3:0]       bit_cnt;
   logic [1:0]       byte_cnt;
   logic             addr_match;
   logic             rw_bit;
   logic             addr_ok;
   logic             upd_arm;
   logic             drive_low;
`ifdef VCM_SLAVE_READ_EN
   logic [7:0]       tx_sh;
   logic             rd_hi;
   logic             mack;
`endif

   // Synchronizer and glitch filter. Each filter output flips only after
   // FILT_LEN consecutive synchronized samples disagree with it.
   always_ff @(posedge CLK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         meta    <= 2'b11;
         sync    <= 2'b11;
         filt    <= 2'b11;
         filt_q  <= 2'b11;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         meta   <= {SCL, SDA};
         sync   <= meta;
         filt_q <= filt;
         for (int i = 0; i < 2; i++) begin
            if (sync[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == CNT_W'(FILT_LEN - 1)) begin
               filt[i] <= sync[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   assign scl_rise  =  filt[1] & ~filt_q[1];
   assign scl_fall  = ~filt[1] &  filt_q[1];
   // START and STOP require SCL to be high both before and after the SDA edge.
   assign start_det = filt[1] & filt_q[1] &  filt_q[0] & ~filt[0];
   assign stop_det  = filt[1] & filt_q[1] & ~filt_q[0] &  filt[0];
   assign rx_byte   = {rx_sh, filt[0]};

`ifdef VCM_SLAVE_READ_EN
   assign addr_ok = addr_match;
`else
   assign addr_ok = addr_match & ~rw_bit;
`endif

   always_ff @(posedge CLK_50 or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_nxt;
   end

   // State moves other than START/STOP happen only on an SCL falling edge.
   // As a result, the SDA drive follows one cycle after that edge.
   always_comb begin
      state_nxt = state;
      if (start_det) begin
         state_nxt = ADDR;
      end else if (stop_det) begin
         state_nxt = IDLE;
      end else if (scl_fall) begin
         case (state)
            ADDR:      if (bit_cnt == 4'd8) state_nxt = addr_ok ? ADDR_ACK : WAIT_STOP;
`ifdef VCM_SLAVE_READ_EN
            ADDR_ACK:  state_nxt = rw_bit ? RD_BYTE : WR_BYTE;
            RD_BYTE:   if (bit_cnt == 4'd8) state_nxt = RD_ACK;
            RD_ACK:    state_nxt = mack ? WAIT_STOP : RD_BYTE;
`else
            ADDR_ACK:  state_nxt = WR_BYTE;
`endif
            WR_BYTE:   if (bit_cnt == 4'd8) state_nxt = WR_ACK;
            WR_ACK:    state_nxt = WR_BYTE;
            default:   state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge CLK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         rx_sh      <= '0;
         pend       <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         addr_match <= 1'b0;
         rw_bit     <= 1'b0;
         upd_arm    <= 1'b0;
         VCM_DATA   <= '0;
         VCM_UPDATE <= 1'b0;
         BUSY       <= 1'b0;
`ifdef VCM_SLAVE_READ_EN
         tx_sh      <= '0;
         rd_hi      <= 1'b1;
         mack       <= 1'b1;
`endif
      end else begin
         upd_arm    <= 1'b0;
         VCM_UPDATE <= upd_arm;

         // Clearing byte_cnt at START/STOP drops any unpaired MSB.
         if (start_det || stop_det) begin
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            addr_match <= 1'b0;
            rw_bit     <= 1'b0;
         end else if (state_nxt != state) begin
            bit_cnt <= '0;
         end else if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
         end

         // BUSY is left alone at a repeated START.
         // It is then resolved by the address that follows.
         if (stop_det)                                     BUSY <= 1'b0;
         else if (state == ADDR && state_nxt == ADDR_ACK)  BUSY <= 1'b1;
         else if (state == ADDR && state_nxt == WAIT_STOP) BUSY <= 1'b0;

         if (scl_rise && !start_det && !stop_det) begin
            case (state)
               ADDR: begin
                  rx_sh <= rx_byte[6:0];
                  if (bit_cnt == 4'd7) begin
                     addr_match <= (rx_sh == SLAVE_ADDR);
                     rw_bit     <= filt[0];
`ifdef VCM_SLAVE_READ_EN
                     rd_hi      <= 1'b1;
`endif
                  end
               end
               WR_BYTE: begin
                  rx_sh <= rx_byte[6:0];
                  if (bit_cnt == 4'd7) begin
                     if (byte_cnt == 2'd0) begin
                        pend     <= rx_byte;
                        byte_cnt <= 2'd1;
                     end else begin
                        VCM_DATA <= {pend, rx_byte};
                        upd_arm  <= 1'b1;
                        byte_cnt <= 2'd0;
                     end
                  end
               end
`ifdef VCM_SLAVE_READ_EN
               RD_ACK:  mack <= filt[0];
`endif
               default: ;
            endcase
         end

`ifdef VCM_SLAVE_READ_EN
         if (scl_fall && state == RD_BYTE && bit_cnt != 4'd8)
            tx_sh <= {tx_sh[6:0], 1'b0};
         // Load the next read byte when leaving ADDR_ACK or RD_ACK into RD_BYTE.
         if (state_nxt == RD_BYTE && state != RD_BYTE) begin
            tx_sh <= rd_hi ? VCM_DATA[15:8] : VCM_DATA[7:0];
            rd_hi <= ~rd_hi;
         end
`endif
      end
   end

   always_comb begin
      drive_low = (state == ADDR_ACK) || (state == WR_ACK);
`ifdef VCM_SLAVE_READ_EN
      if (state == RD_BYTE && !tx_sh[7]) drive_low = 1'b1;
`endif
   end

   assign SDA    = drive_low ? 1'b0 : 1'bz;
   assign STATUS = {addr_match, rw_bit, byte_cnt};

endmodule

// File: tb/tb_vcm_i2c_slave.sv
`timescale 1ns/1ps
module tb_vcm_i2c_slave;

   localparam int         Q    = 8;       // quarter SCL period in CLK_50 cycles
   localparam logic [6:0] ADDR = 7'h0C;
`ifdef VCM_SLAVE_READ_EN
   localparam bit READ_EN = 1'b1;
`else
   localparam bit READ_EN = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl   = 1'b1;
   logic        m_low = 1'b0;
   wire         sda;
   logic [15:0] vcm_data;
   logic        vcm_update;
   logic        busy;
   logic [3:0]  status;

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #10 clk = ~clk;

   vcm_i2c_slave #(.SLAVE_ADDR(ADDR), .FILT_LEN(3)) dut (
      .CLK_50     (clk),
      .RESET_N    (rst_n),
      .SCL        (scl),
      .SDA        (sda),
      .VCM_DATA   (vcm_data),
      .VCM_UPDATE (vcm_update),
      .BUSY       (busy),
      .STATUS     (status)
   );

   int checks = 0;
   int errors = 0;

   typedef struct { string name; int val; } exp_t;
   exp_t        rsp_exp_q[$];
   int          rsp_obs_q[$];
   logic [15:0] upd_q[$];

   // Byte-level reference model of the slave.
   bit          m_active;
   bit          m_pend_v;
   logic [7:0]  m_pend;
   logic [15:0] m_data;
   bit          m_rd_hi;

   bit          dut_low_seen;
   bit          busy_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Update scoreboard: every VCM_UPDATE pulse must match a queued expectation.
   initial forever begin
      @(posedge clk); #1;
      if (vcm_update) begin
         if (upd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL update_unexpected: VCM_DATA=%h with no update expected", vcm_data);
         end else begin
            check("vcm_data_at_update", vcm_data, upd_q.pop_front());
         end
      end
   end

   // Response scoreboard: ACK bits and read bytes seen on the bus.
   initial forever begin
      @(posedge clk); #1;
      while (rsp_obs_q.size() > 0) begin
         int   obs;
         exp_t e;
         obs = rsp_obs_q.pop_front();
         if (rsp_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL response_unexpected: got %0h with nothing expected", obs);
         end else begin
            e = rsp_exp_q.pop_front();
            check(e.name, obs, e.val);
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (sda === 1'b0 && !m_low) dut_low_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic qwait();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bit_io(input bit b, input bit glitch, output bit rx);
      qwait();
      m_low = !b;
      qwait();
      scl = 1'b1;
      qwait();
      rx = sda;
      if (glitch) begin
         scl = 1'b0;
         repeat (2) @(negedge clk);
         scl = 1'b1;
      end
      qwait();
      scl = 1'b0;
   endtask

   task automatic i2c_start();
      if (!scl) begin
         qwait();
         m_low = 1'b0;
         qwait();
         scl = 1'b1;
      end
      qwait();
      m_low = 1'b1;
      qwait();
      scl = 1'b0;
      m_pend_v = 1'b0;
   endtask

   task automatic i2c_stop();
      qwait();
      m_low = 1'b1;
      qwait();
      scl = 1'b1;
      qwait();
      m_low = 1'b0;
      qwait();
      m_pend_v = 1'b0;
      m_active = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int glitch_at);
      bit rx;
      for (int i = 7; i >= 0; i--) bit_io(b[i], (i == glitch_at), rx);
      bit_io(1'b1, 1'b0, rx);
      rsp_obs_q.push_back(int'(rx));
   endtask

   task automatic wr_addr(input logic [7:0] b);
      exp_t e;
      bit   ok;
      ok       = (b[7:1] == ADDR) && (!b[0] || READ_EN);
      m_active = ok;
      m_rd_hi  = 1'b1;
      e.name   = "addr_ack";
      e.val    = ok ? 0 : 1;
      rsp_exp_q.push_back(e);
      send_byte(b, -1);
   endtask

   task automatic wr_data(input logic [7:0] b, input int glitch_at);
      exp_t e;
      e.name = "data_ack";
      e.val  = m_active ? 0 : 1;
      rsp_exp_q.push_back(e);
      if (m_active) begin
         if (m_pend_v) begin
            m_data   = {m_pend, b};
            upd_q.push_back(m_data);
            m_pend_v = 1'b0;
         end else begin
            m_pend   = b;
            m_pend_v = 1'b1;
         end
      end
      send_byte(b, glitch_at);
   endtask

   task automatic rd_byte(input bit last);
      exp_t       e;
      logic [7:0] v;
      bit         rx;
      e.name  = "read_byte";
      e.val   = m_rd_hi ? int'(m_data[15:8]) : int'(m_data[7:0]);
      m_rd_hi = !m_rd_hi;
      rsp_exp_q.push_back(e);
      for (int i = 7; i >= 0; i--) begin
         bit_io(1'b1, 1'b0, rx);
         v[i] = rx;
      end
      bit_io(last, 1'b0, rx);
      rsp_obs_q.push_back(int'(v));
   endtask

   task automatic write_word(input logic [15:0] w);
      i2c_start();
      wr_addr({ADDR, 1'b0});
      wr_data(w[15:8], -1);
      wr_data(w[7:0], -1);
      i2c_stop();
      repeat (4) @(negedge clk);
   endtask

   initial begin
      bit rx;
      m_active = 1'b0;
      m_pend_v = 1'b0;
      m_pend   = '0;
      m_data   = '0;
      m_rd_hi  = 1'b1;
      dut_low_seen = 1'b0;
      busy_seen    = 1'b0;

      // Reset state
      repeat (4) @(negedge clk);
      check("reset_vcm_data", vcm_data, 16'h0000);
      check("reset_update", vcm_update, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_status", status, 4'h0);
      check("reset_sda", sda, 1'b1);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Basic write: S 0x18 0x12 0x34 P
      i2c_start();
      wr_addr(8'h18);
      check("busy_after_addr", busy, 1'b1);
      wr_data(8'h12, -1);
      check("status_after_msb", status, 4'b1001);
      wr_data(8'h34, -1);
      check("status_after_lsb", status, 4'b1000);
      i2c_stop();
      repeat (4) @(negedge clk);
      check("busy_after_stop", busy, 1'b0);
      check("write_1234", vcm_data, m_data);

      // Wrong address: S 0x1A 0xFF P
      dut_low_seen = 1'b0;
      busy_seen    = 1'b0;
      i2c_start();
      wr_addr(8'h1A);
      wr_data(8'hFF, -1);
      i2c_stop();
      repeat (4) @(negedge clk);
      check("wrong_addr_sda_low", dut_low_seen, 1'b0);
      check("wrong_addr_busy", busy_seen, 1'b0);
      check("wrong_addr_data", vcm_data, m_data);

      // Odd-byte write: trailing 0x56 is dropped
      i2c_start();
      wr_addr(8'h18);
      wr_data(8'h12, -1);
      wr_data(8'h34, -1);
      wr_data(8'h56, -1);
      i2c_stop();
      repeat (4) @(negedge clk);
      check("odd_byte_data", vcm_data, m_data);

      // Read back 0xABCD (NACKed address when reads are compiled out)
      write_word(16'hABCD);
      i2c_start();
      wr_addr(8'h19);
      if (m_active) begin
         rd_byte(1'b0);
         rd_byte(1'b1);
      end
      i2c_stop();
      repeat (4) @(negedge clk);
      check("read_busy_after_stop", busy, 1'b0);

      // SCL glitch mid-byte is ignored
      i2c_start();
      wr_addr(8'h18);
      wr_data(8'h5A, 4);
      wr_data(8'hC3, 2);
      i2c_stop();
      repeat (4) @(negedge clk);
      check("glitch_data", vcm_data, m_data);

      // Repeated START after a lone data byte
      i2c_start();
      wr_addr(8'h18);
      wr_data(8'h77, -1);
      i2c_start();
      repeat (4) @(negedge clk);
      check("rstart_byte_cnt", status[1:0], 2'd0);
      wr_addr(8'h18);
      check("rstart_busy", busy, 1'b1);
      i2c_stop();
      repeat (4) @(negedge clk);
      check("rstart_data", vcm_data, m_data);

      // Reset during the LSB byte
      i2c_start();
      wr_addr(8'h18);
      wr_data(8'h11, -1);
      for (int i = 7; i >= 4; i--) bit_io(1'b0, 1'b0, rx);
      m_low = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_sda", sda, 1'b1);
      check("midreset_data", vcm_data, 16'h0000);
      check("midreset_busy", busy, 1'b0);
      check("midreset_status", status, 4'h0);
      m_data   = '0;
      m_pend_v = 1'b0;
      m_active = 1'b0;
      scl      = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      write_word(16'h4321);
      check("after_reset_write", vcm_data, m_data);

      // Randomized transactions
      for (int t = 0; t < 12; t++) begin
         logic [6:0] a;
         logic [7:0] ab;
         bit         rw;
         int         n;
         a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
         rw = READ_EN ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
         ab = {a, rw};
         i2c_start();
         wr_addr(ab);
         if (rw && m_active) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) rd_byte(k == n - 1);
         end else begin
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) wr_data(8'($urandom), -1);
         end
         i2c_stop();
         repeat (4) @(negedge clk);
         check("rand_data", vcm_data, m_data);
         check("rand_busy", busy, 1'b0);
      end

      repeat (20) @(negedge clk);
      check("updates_outstanding", upd_q.size(), 0);
      check("responses_outstanding", rsp_exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
